data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Responder end of the core's data-memory port: word RAM plus a small MMIO block (console TX FIFO,
//  64-bit cycle counter). Reads are combinational so the single-cycle core completes a load in one clock;
//  writes commit on the rising clk edge. The console FIFO drains to an external byte sink via valid/ready.
// PARAMETERS
//  DEPTH       1024            RAM size in 32-bit words (power of 2)
//  RAM_BASE    32'h0000_0000   byte base address of RAM
//  MMIO_BASE   32'h1000_0000   byte base address of MMIO block (16 bytes)
//  FIFO_DEPTH  16              console FIFO entries (power of 2, 2..256)
// PORTS
//  clk                input   1   clock, all state on rising edge
//  rst                input   1   asynchronous active-low reset (0 = reset)
//  mem_write          input   1   store strobe from core
//  mem_read           input   1   load strobe from core
//  mem_address        input   32  byte address from core; bits [1:0] ignored
//  mem_data_to_mem    input   32  store data from core
//  mem_data_from_mem  output  32  load data to core (combinational)
//  con_valid          output  1   console FIFO non-empty
//  con_data           output  8   console FIFO head byte
//  con_ready          input   1   sink accepts head byte this cycle
// BEHAVIOUR
//  Decode: RAM hit = addr in [RAM_BASE, RAM_BASE+4*DEPTH); MMIO hit = addr[31:4]==MMIO_BASE[31:4].
//   MMIO regs by addr[3:2]: 0 CON_TX, 1 CON_STATUS, 2 CYCLE_LO, 3 CYCLE_HI.
//  Reads: mem_data_from_mem = 0 when mem_read=0 or address unmapped. RAM hit -> word at (addr-RAM_BASE)>>2.
//   CON_TX reads 0. CON_STATUS = {16'b0, count[7:0], 5'b0, overflow, full, empty}.
//   CYCLE_LO -> cycle[31:0]; CYCLE_HI -> hi_shadow.
//  Writes (mem_write=1, rising clk): RAM hit stores full word. Unmapped writes ignored.
//   CON_TX: push mem_data_to_mem[7:0] if not full; if full, byte dropped and overflow<=1 (sticky).
//   CON_STATUS: any write clears overflow. CYCLE_LO/HI writes ignored.
//  mem_read and mem_write both high: write commits at edge; read returns pre-write value that cycle.
//  Cycle counter: 64-bit, +1 every clk, wraps 2^64-1 -> 0. Load of CYCLE_LO (mem_read=1) latches
//   cycle[63:32] into hi_shadow at that edge, so LO-then-HI yields a coherent 64-bit sample.
//  Console FIFO: first-word-fall-through; con_valid=!empty; con_data=head entry (0 when empty).
//   Pop when con_valid & con_ready. Push+pop same cycle: both occur, count unchanged, including when full
//   (push accepted, no overflow). Empty + push: con_valid rises next cycle (1-cycle latency).
//   Pointers wrap modulo FIFO_DEPTH; count in 0..FIFO_DEPTH.
//  Reset (rst=0, async): cycle=0, hi_shadow=0, FIFO ptrs/count=0, overflow=0 -> con_valid=0,
//   con_data=0, status empty=1. RAM contents not reset. Reset mid-burst discards queued bytes.
//  mem_data_from_mem is combinational from inputs/state; during reset it reflects reset state.
// TESTING
//  1 RAM: store 32'hDEAD_BEEF @0x40, load @0x40 next cycle -> 32'hDEAD_BEEF; load @0x42 -> same word.
//  2 Unmapped: load @0x2000_0000 -> 0; store there then reload RAM @0x0 -> unchanged.
//  3 FIFO: con_ready=0, push 17 bytes 0x41.. -> status count=16 full=1 overflow=1, 17th lost; con_ready=1
//     -> 16 bytes 0x41..0x50 in order, then empty=1; write CON_STATUS -> overflow=0.
//  4 Full + simultaneous push/pop: FIFO full, con_ready=1, push 0x5A -> count stays 16, overflow=0,
//     0x5A emerges last.
//  5 Cycle: after reset release, N edges -> CYCLE_LO=N; force cycle=64'h0000_0000_FFFF_FFFF, load LO
//     (0xFFFF_FFFF) then HI next cycle -> HI=0 (shadow), next LO read wraps to 0 and HI=1.
//  6 Async reset asserted mid-drain (between clk edges) -> con_valid=0, count=0 immediately; RAM retained.

Source files
------------

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory responder: word RAM, console TX FIFO and 64-bit cycle counter MMIO
module data_mem_responder #(
    parameter int          DEPTH      = 1024,
    parameter logic [31:0] RAM_BASE   = 32'h0000_0000,
    parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_data_to_mem,
    output logic [31:0] mem_data_from_mem,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready
);

    localparam int          AW        = $clog2(DEPTH);
    localparam int          FAW       = $clog2(FIFO_DEPTH);
    localparam int          CW        = FAW + 1;
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);

    localparam logic [1:0] REG_CON_TX     = 2'd0;
    localparam logic [1:0] REG_CON_STATUS = 2'd1;
    localparam logic [1:0] REG_CYCLE_LO   = 2'd2;
    localparam logic [1:0] REG_CYCLE_HI   = 2'd3;

    logic [31:0] ram_mem [DEPTH];
    logic [7:0]  fifo_mem [FIFO_DEPTH];

    logic [63:0]    cycle_q, cycle_d;
    logic [31:0]    hi_shadow_q, hi_shadow_d;
    logic [FAW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FAW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           overflow_q, overflow_d;

    logic [31:0]   ram_off;
    logic [AW-1:0] ram_idx;
    logic          ram_hit;
    logic          mmio_hit;
    logic [1:0]    mmio_reg;
    logic          ram_we;
    logic          push_req;
    logic          push_acc;
    logic          pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic [7:0]    count8;
    logic          unused_bits;

    // Subtracting the base first lets one unsigned compare cover both range ends.
    assign ram_off     = mem_address - RAM_BASE;
    assign ram_hit     = ram_off < RAM_BYTES;
    assign ram_idx     = ram_off[AW+1:2];
    assign mmio_hit    = mem_address[31:4] == MMIO_BASE[31:4];
    assign mmio_reg    = mem_address[3:2];
    assign unused_bits = ^{ram_off[31:AW+2], ram_off[1:0]};

    assign fifo_empty = count_q == '0;
    assign fifo_full  = count_q == CW'(FIFO_DEPTH);
    assign count8     = 8'(count_q);

    assign ram_we   = mem_write && ram_hit;
    assign push_req = mem_write && mmio_hit && (mmio_reg == REG_CON_TX);
    assign pop      = con_valid && con_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign push_acc = push_req && (!fifo_full || pop);

    assign con_valid = !fifo_empty;
    assign con_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];

    always_comb begin
        mem_data_from_mem = 32'h0;
        if (mem_read) begin
            if (ram_hit) begin
                mem_data_from_mem = ram_mem[ram_idx];
            end else if (mmio_hit) begin
                case (mmio_reg)
                    REG_CON_TX:     mem_data_from_mem = 32'h0;
                    REG_CON_STATUS: mem_data_from_mem = {16'h0, count8, 5'b0, overflow_q, fifo_full, fifo_empty};
                    REG_CYCLE_LO:   mem_data_from_mem = cycle_q[31:0];
                    REG_CYCLE_HI:   mem_data_from_mem = hi_shadow_q;
                    default:        mem_data_from_mem = 32'h0;
                endcase
            end
        end
    end

    always_comb begin
        cycle_d     = cycle_q + 64'd1;
        hi_shadow_d = hi_shadow_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;

        // Latching the upper half on a LO load keeps a LO-then-HI pair coherent.
        if (mem_read && mmio_hit && (mmio_reg == REG_CYCLE_LO)) begin
            hi_shadow_d = cycle_q[63:32];
        end

        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + FAW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FAW'(1);
        end
        case ({push_acc, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (push_req && !push_acc) begin
            overflow_d = 1'b1;
        end else if (mem_write && mmio_hit && (mmio_reg == REG_CON_STATUS)) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_q     <= 64'h0;
            hi_shadow_q <= 32'h0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            cycle_q     <= cycle_d;
            hi_shadow_q <= hi_shadow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage arrays carry no reset; emptiness is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_mem[ram_idx] <= mem_data_to_mem;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            fifo_mem[wr_ptr_q] <= mem_data_to_mem[7:0];
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

    localparam logic [31:0] A_TX     = 32'h1000_0000;
    localparam logic [31:0] A_STATUS = 32'h1000_0004;
    localparam logic [31:0] A_LO     = 32'h1000_0008;
    localparam logic [31:0] A_HI     = 32'h1000_000C;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_write = 1'b0;
    logic        mem_read = 1'b0;
    logic [31:0] mem_address = 32'h0;
    logic [31:0] mem_data_to_mem = 32'h0;
    logic [31:0] mem_data_from_mem;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    data_mem_responder dut (
        .clk               (clk),
        .rst               (rst),
        .mem_write         (mem_write),
        .mem_read          (mem_read),
        .mem_address       (mem_address),
        .mem_data_to_mem   (mem_data_to_mem),
        .mem_data_from_mem (mem_data_from_mem),
        .con_valid         (con_valid),
        .con_data          (con_data),
        .con_ready         (con_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        mem_write       = 1'b1;
        mem_address     = addr;
        mem_data_to_mem = data;
        @(posedge clk);
        @(negedge clk);
        mem_write = 1'b0;
    endtask

    task automatic load(input logic [31:0] addr, output logic [31:0] data);
        mem_read    = 1'b1;
        mem_address = addr;
        #1;
        data     = mem_data_from_mem;
        mem_read = 1'b0;
    endtask

    logic [31:0] rd;

    initial begin
        // Reset state
        #1;
        check("rst_con_valid", con_valid, 0);
        check("rst_con_data", con_data, 0);
        load(A_STATUS, rd);
        check("rst_status", rd, 32'h0000_0001);

        // Cycle counter counts edges since reset release
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        load(A_LO, rd);
        check("cycle_n", rd, 32'd5);

        // RAM
        store(32'h40, 32'hDEAD_BEEF);
        load(32'h40, rd);
        check("ram_rd", rd, 32'hDEAD_BEEF);
        load(32'h42, rd);
        check("ram_rd_unaligned", rd, 32'hDEAD_BEEF);
        mem_address = 32'h40;
        #1;
        check("rd_gated", mem_data_from_mem, 0);
        mem_read = 1'b1; mem_write = 1'b1; mem_data_to_mem = 32'h1234_5678;
        #1;
        check("rd_wr_same_cycle", mem_data_from_mem, 32'hDEAD_BEEF);
        @(posedge clk);
        @(negedge clk);
        mem_write = 1'b0;
        #1;
        check("rd_after_wr", mem_data_from_mem, 32'h1234_5678);
        mem_read = 1'b0;
        store(32'h44, 32'hCAFE_F00D);
        store(32'hFFC, 32'hA5A5_0001);
        load(32'hFFC, rd);
        check("ram_top_word", rd, 32'hA5A5_0001);

        // Unmapped
        store(32'h0, 32'h1111_1111);
        load(32'h2000_0000, rd);
        check("unmapped_rd", rd, 0);
        load(32'h1000, rd);
        check("past_ram_rd", rd, 0);
        store(32'h2000_0000, 32'hFFFF_FFFF);
        store(32'h1000, 32'hFFFF_FFFF);
        load(32'h0, rd);
        check("unmapped_wr_ignored", rd, 32'h1111_1111);
        load(A_TX, rd);
        check("con_tx_rd", rd, 0);

        // FIFO overflow then drain
        for (int i = 0; i < 17; i++) store(A_TX, 32'h41 + i);
        load(A_STATUS, rd);
        check("fifo_full_status", rd, 32'h0000_1007 & 32'hFFFF_FFFE);
        check("fifo_head", con_data, 8'h41);
        con_ready = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain_%0d", i), {con_valid, con_data}, {1'b1, 8'(8'h41 + i)});
            @(posedge clk);
            @(negedge clk);
            #1;
        end
        con_ready = 1'b0;
        check("drain_empty_valid", con_valid, 0);
        load(A_STATUS, rd);
        check("drain_status", rd, 32'h0000_0005);
        store(A_STATUS, 32'h0);
        load(A_STATUS, rd);
        check("ovf_cleared", rd, 32'h0000_0001);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 16; i++) store(A_TX, 32'h60 + i);
        load(A_STATUS, rd);
        check("full_status", rd, 32'h0000_1002);
        con_ready = 1'b1;
        store(A_TX, 32'h5A);
        con_ready = 1'b0;
        load(A_STATUS, rd);
        check("full_pushpop_status", rd, 32'h0000_1002);
        con_ready = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("pp_drain_%0d", i), con_data, (i == 15) ? 8'h5A : 8'(8'h61 + i));
            @(posedge clk);
            @(negedge clk);
            #1;
        end
        con_ready = 1'b0;
        check("pp_empty", con_valid, 0);

        // Cycle counter carry into upper half with shadow
        force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.cycle_q;
        mem_read = 1'b1; mem_address = A_LO;
        #1;
        check("cyc_lo_max", mem_data_from_mem, 32'hFFFF_FFFF);
        @(posedge clk);
        @(negedge clk);
        mem_address = A_HI;
        #1;
        check("cyc_hi_shadow0", mem_data_from_mem, 0);
        mem_address = A_LO;
        #1;
        check("cyc_lo_wrap", mem_data_from_mem, 0);
        @(posedge clk);
        @(negedge clk);
        mem_address = A_HI;
        #1;
        check("cyc_hi_shadow1", mem_data_from_mem, 1);
        mem_read = 1'b0;

        // Async reset mid-drain
        for (int i = 0; i < 3; i++) store(A_TX, 32'h70 + i);
        con_ready = 1'b1;
        @(posedge clk);
        #2;
        check("pre_rst_valid", {con_valid, con_data}, {1'b1, 8'h71});
        rst = 1'b0;
        #1;
        check("async_rst_valid", con_valid, 0);
        load(A_STATUS, rd);
        check("async_rst_status", rd, 32'h0000_0001);
        @(negedge clk);
        rst = 1'b1;
        con_ready = 1'b0;
        load(32'h44, rd);
        check("ram_retained", rd, 32'hCAFE_F00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
